dmem_bus_bridge: RTL and testbench

- Sits directly downstream of the load/store unit, between the LSU and the system data bus.
- Turns the LSU's single-cycle data-memory request into a registered valid/ready bus transaction. Fields used: byte address, 4-bit byte-write strobe, lane-aligned write data, load request.
- Stalls the core until the bus acknowledges.
- Returns load data to the LSU right-aligned to byte 0, so the LSU's sign/zero extension of bits [15:0]/[7:0] is correct for any byte offset.

---
 rtl/dmem_bus_bridge_if.sv | 22 ++
 rtl/dmem_bus_bridge.sv | 139 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_bridge_if.sv
// System data bus between the LSU bridge (master) and the memory slave.
// Valid/ready handshake with word address, byte enables and a timeout error pulse.
interface dmem_bus_bridge_if;
   logic        bus_valid;
   logic        bus_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_valid, bus_addr, bus_we, bus_be, bus_wdata, bus_err,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_addr, bus_we, bus_be, bus_wdata, bus_err,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Converts single-cycle LSU data-memory requests into registered valid/ready bus
// transactions and right-aligns load data. Optional bus-wait abort: DMEM_TIMEOUT_EN.
module dmem_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] RD_ERR_DATA    = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           data_addr,
   input  logic [3:0]            dmem_wr,
   input  logic [31:0]           datamem_wr_o,
   input  logic                  mem_rd,
   output logic [31:0]           datamem_rd_in,
   output logic                  stall,
   dmem_bus_bridge_if.master     bus
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("dmem_bus_bridge: TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, wdata_reg, rdata_reg;
   logic [3:0]  be_reg;
   logic        we_reg;
   logic [1:0]  off_reg;

   logic        is_wr, req;
   logic        launch, complete, timeout_hit, timeout_limit;
   logic        in_req;

   // A store strobe overrides a simultaneous load request.
   assign is_wr = |dmem_wr;
   assign req   = mem_rd | is_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      stall       = 1'b0;
      launch      = 1'b0;
      complete    = 1'b0;
      timeout_hit = 1'b0;
      case (state_reg)
         IDLE: begin
            stall = req;
            if (req) begin
               launch     = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (bus.bus_ready) begin
               complete   = 1'b1;
               state_next = DONE;
            end else if (timeout_limit) begin
               timeout_hit = 1'b1;
               state_next  = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         be_reg    <= '0;
         we_reg    <= 1'b0;
         off_reg   <= '0;
      end else begin
         if (launch) begin
            addr_reg  <= {data_addr[31:2], 2'b00};
            be_reg    <= is_wr ? dmem_wr : 4'b1111;
            wdata_reg <= datamem_wr_o;
            we_reg    <= is_wr;
            off_reg   <= data_addr[1:0];
         end
         // Shift the addressed byte down to lane 0 so the LSU extension works.
         if (complete && !we_reg) begin
            rdata_reg <= bus.bus_rdata >> {off_reg, 3'b000};
         end else if (timeout_hit && !we_reg) begin
            rdata_reg <= RD_ERR_DATA;
         end
      end
   end

`ifdef DMEM_TIMEOUT_EN
   logic [15:0] cnt_reg;
   logic        err_reg;

   assign timeout_limit = (cnt_reg == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         if (launch) begin
            cnt_reg <= '0;
         end else if (in_req && !bus.bus_ready) begin
            cnt_reg <= cnt_reg + 16'd1;
         end
         // High only for the DONE cycle that follows an abort.
         err_reg <= timeout_hit;
      end
   end

   assign bus.bus_err = err_reg;
`else
   assign timeout_limit = 1'b0;
   assign bus.bus_err   = 1'b0;
`endif

   assign in_req        = (state_reg == REQ);
   assign bus.bus_valid = in_req;
   assign bus.bus_we    = in_req & we_reg;
   assign bus.bus_be    = in_req ? be_reg : 4'b0000;
   assign bus.bus_addr  = addr_reg;
   assign bus.bus_wdata = wdata_reg;
   assign datamem_rd_in = rdata_reg;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: scoreboard of expected bus requests and
// load results; define DMEM_TIMEOUT_EN to also exercise the abort path.
module tb_dmem_bus_bridge;

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_addr = '0;
   logic [3:0]  dmem_wr = '0;
   logic [31:0] datamem_wr_o = '0;
   logic        mem_rd = 1'b0;
   logic [31:0] datamem_rd_in;
   logic        stall;

   dmem_bus_bridge_if bus_if ();

   dmem_bus_bridge #(
      .TIMEOUT_CYCLES (TO),
      .RD_ERR_DATA    (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_addr     (data_addr),
      .dmem_wr       (dmem_wr),
      .datamem_wr_o  (datamem_wr_o),
      .mem_rd        (mem_rd),
      .datamem_rd_in (datamem_rd_in),
      .stall         (stall),
      .bus           (bus_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
   } txn_t;

   txn_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_rd = '0;
   logic [31:0] last_addr = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One LSU access; waits < 0 means the slave never raises ready.
   task automatic access(input string name, input logic [31:0] addr, input logic [3:0] wr,
                         input logic [31:0] wd, input logic rd, input logic [31:0] srd,
                         input int waits, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_stall);
      txn_t        t, got;
      int          stall_cycles = 0;
      int          valid_cycles = 0;
      int          cyc = 0;
      logic [31:0] addr0 = '0;
      bit          done = 0;
      t.addr  = {addr[31:2], 2'b00};
      t.we    = |wr;
      t.be    = (|wr) ? wr : 4'b1111;
      t.wdata = wd;
      t.rd    = (|wr) ? last_rd : exp_rd;
      t.err   = exp_err;
      sb_q.push_back(t);
      @(posedge clk); #1;
      data_addr    = addr;
      dmem_wr      = wr;
      datamem_wr_o = wd;
      mem_rd       = rd;
      bus_if.bus_rdata = srd;
      bus_if.bus_ready = 1'b0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (stall) stall_cycles++;
         if (bus_if.bus_valid) begin
            if (valid_cycles == 0) begin
               check({name, "_sb_depth"}, sb_q.size(), 1);
               got = sb_q.pop_front();
               check({name, "_addr"},  bus_if.bus_addr,  got.addr);
               check({name, "_we"},    bus_if.bus_we,    got.we);
               check({name, "_be"},    bus_if.bus_be,    got.be);
               check({name, "_wdata"}, bus_if.bus_wdata, got.wdata);
               addr0 = bus_if.bus_addr;
            end else begin
               check({name, "_addr_stable"}, bus_if.bus_addr, addr0);
            end
            bus_if.bus_ready = (valid_cycles == waits);
            valid_cycles++;
         end else begin
            bus_if.bus_ready = 1'b0;
            if (valid_cycles > 0 && !stall) begin
               check({name, "_rd_data"}, datamem_rd_in, got.rd);
               check({name, "_err"},     bus_if.bus_err, got.err);
               check({name, "_stall"},   stall_cycles, exp_stall);
               check({name, "_cycles"},  cyc, exp_stall + 1);
               check({name, "_done_be"}, bus_if.bus_be, 4'b0000);
               done = 1;
            end
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s_budget: observed no completion expected DONE within 200 cycles", name);
      end
      last_rd   = got.rd;
      last_addr = t.addr;
      $display("TXN %s addr=%h we=%0d be=%b rd=%h stall=%0d", name, t.addr, t.we, t.be,
               datamem_rd_in, stall_cycles);
   endtask

   task automatic idle_step(input string name);
      @(posedge clk); #1;
      dmem_wr = '0;
      mem_rd  = 1'b0;
      @(negedge clk);
      check({name, "_stall"}, stall, 1'b0);
      check({name, "_valid"}, bus_if.bus_valid, 1'b0);
      check({name, "_we"},    bus_if.bus_we, 1'b0);
      check({name, "_be"},    bus_if.bus_be, 4'b0000);
      check({name, "_err"},   bus_if.bus_err, 1'b0);
      check({name, "_addr"},  bus_if.bus_addr, last_addr);
      check({name, "_rd"},    datamem_rd_in, last_rd);
   endtask

   initial begin
      txn_t rt, rgot;
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rdata = '0;

      repeat (2) @(negedge clk);
      check("rst_valid", bus_if.bus_valid, 1'b0);
      check("rst_be",    bus_if.bus_be, 4'b0000);
      check("rst_addr",  bus_if.bus_addr, 32'h0);
      check("rst_wdata", bus_if.bus_wdata, 32'h0);
      check("rst_rd",    datamem_rd_in, 32'h0);
      check("rst_stall", stall, 1'b0);
      check("rst_err",   bus_if.bus_err, 1'b0);
      rst_n = 1'b1;
      idle_step("idle0");

      access("sw",  32'h1000_0004, 4'b1111, 32'hA5A5_1234, 1'b0, 32'h0, 0,
             32'h0, 1'b0, 2);
      idle_step("idle1");
      access("lb",  32'h2000_0003, 4'b0000, 32'h0, 1'b1, 32'h8877_6655, 0,
             32'h0000_0088, 1'b0, 2);
      idle_step("idle2");
      access("lh",  32'h2000_0002, 4'b0000, 32'h0, 1'b1, 32'hBEEF_0000, 4,
             32'h0000_BEEF, 1'b0, 6);
      access("sb",  32'h0000_0003, 4'b1000, 32'h5A00_0000, 1'b0, 32'h0, 0,
             32'h0, 1'b0, 2);
      access("lw",  32'h0000_0008, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D, 1,
             32'hCAFE_F00D, 1'b0, 3);
      access("wr_wins", 32'h0000_0011, 4'b0010, 32'h0000_7700, 1'b1, 32'h1111_2222, 0,
             32'h0, 1'b0, 2);
      idle_step("idle3");

      // Reset dropped in the second REQ cycle of a load.
      rt.addr = 32'h0000_0040; rt.we = 1'b0; rt.be = 4'b1111; rt.wdata = 32'h0;
      rt.rd = 32'h0; rt.err = 1'b0;
      sb_q.push_back(rt);
      @(posedge clk); #1;
      data_addr = 32'h0000_0040; dmem_wr = 4'b0000; mem_rd = 1'b1;
      bus_if.bus_ready = 1'b0;
      @(negedge clk);
      check("rstm_idle_stall", stall, 1'b1);
      @(negedge clk);
      check("rstm_valid1", bus_if.bus_valid, 1'b1);
      rgot = sb_q.pop_front();
      check("rstm_addr", bus_if.bus_addr, rgot.addr);
      @(negedge clk);
      check("rstm_valid2", bus_if.bus_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rstm_valid_drop", bus_if.bus_valid, 1'b0);
      check("rstm_rd", datamem_rd_in, 32'h0);
      check("rstm_addr_clr", bus_if.bus_addr, 32'h0);
      mem_rd = 1'b0;
      #1;
      check("rstm_stall", stall, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd   = 32'h0;
      last_addr = 32'h0;
      $display("TXN rst_mid addr=%h dropped", rt.addr);
      idle_step("idle4");
      access("lw_post", 32'h0000_0044, 4'b0000, 32'h0, 1'b1, 32'h1234_5678, 0,
             32'h1234_5678, 1'b0, 2);

`ifdef DMEM_TIMEOUT_EN
      idle_step("idle5");
      access("lw_to",   32'h0000_0050, 4'b0000, 32'h0, 1'b1, 32'hDEAD_BEEF, -1,
             32'h0000_0000, 1'b1, TO + 1);
      idle_step("idle6");
      access("lw_edge", 32'h0000_0052, 4'b0000, 32'h0, 1'b1, 32'hDEAD_BEEF, TO - 1,
             32'h0000_DEAD, 1'b0, TO + 1);
`endif
      idle_step("idle_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
